lcd_tgen_seq: RTL and testbench



---
 rtl/lcd_tgen_seq.sv | 137 +++++++++++++
 tb/tb_lcd_tgen_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_tgen_seq.sv
// lcd_tgen_seq: vs/hs/de timing generator for the 320x240 RGB panel path.
// It starts and stops only on frame boundaries and steps a test-pattern index every FRAMES_PER_PAT frames.
module lcd_tgen_seq #(
  parameter int H_SYNC         = 10,
  parameter int H_BP           = 38,
  parameter int H_ACT          = 320,
  parameter int H_FP           = 20,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 16,
  parameter int V_ACT          = 240,
  parameter int V_FP           = 4,
  parameter int FRAMES_PER_PAT = 60,
  parameter int NUM_PAT        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pat_hold,
  output logic       vs_out,
  output logic       hs_out,
  output logic       de_out,
  output logic       frame_start,
  output logic [2:0] pat_sel,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] H_DE_LO  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_DE_HI  = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_DE_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_DE_HI  = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [7:0] F_LAST   = 8'(FRAMES_PER_PAT - 1);
  localparam logic [2:0] P_LAST   = 3'(NUM_PAT - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [2:0] pat_sel_q, pat_sel_d;
  logic       vs_q, vs_d;
  logic       hs_q, hs_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;
  logic       busy_q, busy_d;

  logic running;
  logic frame_end;

  assign running   = (state_q == RUN) || (state_q == DRAIN);
  assign frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = '0;
    vcnt_d    = '0;
    fcnt_d    = fcnt_q;
    pat_sel_d = pat_sel_q;

    if (running) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
      end
    end

    // Dropping en never truncates a frame: RUN falls into DRAIN and only frame end returns to IDLE.
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = frame_end ? IDLE : DRAIN;
      DRAIN:   if (frame_end) state_d = en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (running && frame_end && !pat_hold) begin
      if (fcnt_q == F_LAST) begin
        fcnt_d    = '0;
        pat_sel_d = (pat_sel_q == P_LAST) ? '0 : pat_sel_q + 3'd1;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end

    hs_d   = running && (hcnt_q < H_SYNC_C);
    vs_d   = running && (vcnt_q < V_SYNC_C);
    de_d   = running && (hcnt_q >= H_DE_LO) && (hcnt_q < H_DE_HI)
                     && (vcnt_q >= V_DE_LO) && (vcnt_q < V_DE_HI);
    fs_d   = running && (hcnt_q == '0) && (vcnt_q == '0);
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      fcnt_q    <= '0;
      pat_sel_q <= '0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      fcnt_q    <= fcnt_d;
      pat_sel_q <= pat_sel_d;
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
    end
  end

  assign vs_out      = vs_q;
  assign hs_out      = hs_q;
  assign de_out      = de_q;
  assign frame_start = fs_q;
  assign pat_sel     = pat_sel_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_tgen_seq.sv
// Bench for lcd_tgen_seq on a reduced 12x7 raster: the stimulus queues the expected per-frame pattern,
// and a monitor checks each frame's sync/de shape against it.
module tb_lcd_tgen_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pat_hold;
  logic       vs_out;
  logic       hs_out;
  logic       de_out;
  logic       frame_start;
  logic [2:0] pat_sel;
  logic       busy;

  lcd_tgen_seq #(
    .H_SYNC(2), .H_BP(1), .H_ACT(8), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .FRAMES_PER_PAT(2), .NUM_PAT(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pat_hold(pat_hold),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .frame_start(frame_start), .pat_sel(pat_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int de;
  } rec_t;

  rec_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int idle_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int pat);
    rec_t r;
    r.pat = pat;
    r.de  = 32;
    sb.push_back(r);
  endfunction

  // Monitor: frame k=0 is the frame_start clock; 12 clocks per line, 84 per frame.
  bit   in_frame  = 1'b0;
  int   k         = 0;
  int   de_cnt    = 0;
  int   shape_err = 0;
  int   pat_frame = 0;
  int   pat_prev  = 0;
  int   line, col;
  bit   exp_hs, exp_vs, exp_de;
  rec_t cur;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      pat_prev = 0;
    end else begin
      if (in_frame) begin
        k++;
        if (k == 84) begin
          chk("frame_de_count", de_cnt, cur.de);
          chk("frame_shape", shape_err, 0);
          in_frame = 1'b0;
        end
      end
      if (frame_start) begin
        if (in_frame) chk("frame_length", k, 84);
        chk("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) cur = sb.pop_front();
        else begin
          cur.pat = -1;
          cur.de  = 32;
        end
        chk("frame_pat_sel", int'(pat_sel), cur.pat);
        chk("pat_settled_before_fs", int'(pat_sel), pat_prev);
        in_frame  = 1'b1;
        k         = 0;
        de_cnt    = 0;
        shape_err = 0;
        pat_frame = int'(pat_sel);
      end
      if (in_frame) begin
        line   = k / 12;
        col    = k % 12;
        exp_hs = (col < 2);
        exp_vs = (line < 1);
        exp_de = (line >= 2) && (line <= 5) && (col >= 3) && (col <= 10);
        if (hs_out !== exp_hs || vs_out !== exp_vs || de_out !== exp_de || busy !== 1'b1)
          shape_err++;
        if (de_out && int'(pat_sel) != pat_frame) shape_err++;
        if (de_out) de_cnt++;
      end else if (vs_out || hs_out || de_out || frame_start) begin
        idle_err++;
      end
      pat_prev = int'(pat_sel);
    end
  end

  task automatic wait_fs(output int cycles, output int busy_lo);
    cycles  = 0;
    busy_lo = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!busy) busy_lo++;
    end while (!frame_start && cycles < 200);
    chk("fs_within_budget", frame_start ? 1 : 0, 1);
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_vs"}, int'(vs_out), 0);
    chk({tag, "_hs"}, int'(hs_out), 0);
    chk({tag, "_de"}, int'(de_out), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pat"}, int'(pat_sel), 0);
  endtask

  initial begin
    int cyc, bl, lows;
    rst      = 1'b1;
    en       = 1'b0;
    pat_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_low("reset");

    // Free run for 7 frames: pattern steps every 2 frames and wraps after 3.
    push(0); push(0); push(1); push(1); push(2); push(2); push(0);
    rst = 1'b0;
    en  = 1'b1;
    wait_fs(cyc, bl);
    chk("first_fs_latency", cyc, 2);
    chk("first_fs_busy", int'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      wait_fs(cyc, bl);
      chk("frame_period", cyc, 84);
    end

    // Frame 7: drop en at hcnt=5,vcnt=3; the frame must still complete.
    repeat (40) @(negedge clk);
    en = 1'b0;
    repeat (43) @(negedge clk);
    chk("drain_last_clock_busy", int'(busy), 1);
    @(negedge clk);
    chk("after_fe_busy", int'(busy), 0);
    chk("after_fe_fs", int'(frame_start), 0);
    repeat (10) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Restart from idle, then drop and re-raise en inside the same frame.
    push(0); push(1);
    en = 1'b1;
    @(negedge clk);
    chk("restart_fs_clk1", int'(frame_start), 0);
    chk("restart_busy_clk1", int'(busy), 0);
    @(negedge clk);
    chk("restart_fs_clk2", int'(frame_start), 1);
    chk("restart_busy_clk2", int'(busy), 1);
    repeat (10) @(negedge clk);
    en   = 1'b0;
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busy) lows++;
    end
    en = 1'b1;
    wait_fs(cyc, bl);
    chk("drain_rejoin_gap", cyc, 34);
    chk("drain_busy_low_clocks", lows + bl, 0);

    // Hold pattern 1 across 4 frames, then release.
    pat_hold = 1'b1;
    push(1); push(1); push(1); push(1);
    for (int i = 0; i < 4; i++) begin
      wait_fs(cyc, bl);
      chk("hold_period", cyc, 84);
    end
    pat_hold = 1'b0;
    push(1); push(2);
    wait_fs(cyc, bl);
    wait_fs(cyc, bl);
    chk("pat_after_release", int'(pat_sel), 2);

    // Asynchronous reset in the middle of an active line.
    repeat (30) @(negedge clk);
    chk("pre_rst_de", int'(de_out), 1);
    #2 rst = 1'b1;
    #1 chk_all_low("async_rst");
    @(negedge clk);
    @(negedge clk);
    push(0);
    rst = 1'b0;
    wait_fs(cyc, bl);
    chk("post_rst_fs_latency", cyc, 2);
    en = 1'b0;
    repeat (84) @(negedge clk);
    chk("final_busy", int'(busy), 0);
    repeat (6) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    chk("idle_outputs_high_clocks", idle_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
